// File: rtl/nv_ram_rws_param.sv
// Parametrised 1W/1R RAM model: per-lane masked writes, optional read-during-write bypass,
// read latency 1 (OUT_REG=0) or 2 (OUT_REG=1), held read data with a valid pulse, power-down gating.
module nv_ram_rws_param #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int DW      = 1088,
  parameter int MW      = 17,
  parameter int BYPASS  = 1,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [MW-1:0] wmask,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd
);

  localparam int LW = DW / MW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  logic          pd;
  logic          rd_en;
  logic          wr_en;
  logic          ra_ok;
  logic          wa_ok;
  logic          hit;
  logic [DW-1:0] bit_mask;
  logic [DW-1:0] rd_old;
  logic [DW-1:0] rd_new;
  logic [DW-1:0] rd_q;
  logic          v1_q;
  logic [30:0]   unused_pwr;

  assign pd         = pwrbus_ram_pd[0];
  assign unused_pwr = pwrbus_ram_pd[31:1];
  assign rd_en      = re & ~pd;
  // Writes are held off during reset so the first write lands on the first edge after release.
  assign wr_en      = we & ~pd & rstn;
  assign ra_ok      = int'(ra) < DEPTH;
  assign wa_ok      = int'(wa) < DEPTH;
  assign hit        = (BYPASS != 0) && wr_en && wa_ok && (wa == ra);

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < MW; i++) begin
      bit_mask[i*LW +: LW] = {LW{wmask[i]}};
    end
  end

  assign rd_old = ra_ok ? mem[ra[IW-1:0]] : '0;
  assign rd_new = hit ? ((di & bit_mask) | (rd_old & ~bit_mask)) : rd_old;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && wa_ok) begin
      for (int i = 0; i < MW; i++) begin
        if (wmask[i]) begin
          mem[wa[IW-1:0]][i*LW +: LW] <= di[i*LW +: LW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= rd_en;
      if (rd_en) begin
        rd_q <= rd_new;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] d2_q;
      logic          v2_q;

      // Stage 2 keeps draining stage 1 even while powered down.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          d2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            d2_q <= rd_q;
          end
        end
      end

      assign dout     = d2_q;
      assign dout_vld = v2_q;
    end else begin : g_noreg
      assign dout     = rd_q;
      assign dout_vld = v1_q;
    end
  endgenerate

  a_no_x_ctrl : assert property (@(posedge clk) disable iff (!rstn) !$isunknown({re, we}));

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Bench for nv_ram_rws_param: four configurations driven in parallel, scoreboarded every cycle.
module tb_nv_ram_rws_param;
  localparam int DW = 1088;
  localparam int AW = 6;
  localparam int MW = 17;
  localparam int LW = DW / MW;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [AW-1:0] wa = '0;
  logic [MW-1:0] wmask = '0;
  logic [DW-1:0] di = '0;
  logic [31:0]   pwr = '0;

  logic [DW-1:0] dout_a [NI];
  logic          vld_a  [NI];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Instance k: bypass / latency / depth
  function automatic int byp(int k); return (k == 0 || k == 2) ? 1 : 0; endfunction
  function automatic int lat(int k); return (k >= 2) ? 2 : 1; endfunction
  function automatic int dep(int k); return (k == 3) ? 48 : 64; endfunction

  always #5 clk = ~clk;

  nv_ram_rws_param #(.DEPTH(64), .AW(AW), .DW(DW), .MW(MW), .BYPASS(1), .OUT_REG(0)) u0 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_a[0]), .dout_vld(vld_a[0]),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr));
  nv_ram_rws_param #(.DEPTH(64), .AW(AW), .DW(DW), .MW(MW), .BYPASS(0), .OUT_REG(0)) u1 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_a[1]), .dout_vld(vld_a[1]),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr));
  nv_ram_rws_param #(.DEPTH(64), .AW(AW), .DW(DW), .MW(MW), .BYPASS(1), .OUT_REG(1)) u2 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_a[2]), .dout_vld(vld_a[2]),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr));
  nv_ram_rws_param #(.DEPTH(48), .AW(AW), .DW(DW), .MW(MW), .BYPASS(0), .OUT_REG(1)) u3 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_a[3]), .dout_vld(vld_a[3]),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr));

  // Reference: memory image plus a table of read results indexed by the cycle they must appear.
  logic [DW-1:0] m      [NI][64];
  logic          pend_v [NI][4];
  logic [DW-1:0] pend_d [NI][4];
  logic [DW-1:0] exp_d  [NI];

  task automatic report(string nm, int k, logic [DW-1:0] ad, logic av,
                        logic [DW-1:0] ed, logic ev);
    n_chk++;
    if (ad !== ed || av !== ev) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got dout hi=%h lo=%h vld=%b, expected hi=%h lo=%h vld=%b",
               nm, k, $time, ad[DW-1 -: 64], ad[127:0], av, ed[DW-1 -: 64], ed[127:0], ev);
    end
  endtask

  // Inputs change at negedge+1, so at negedge they are exactly what the preceding posedge sampled.
  always @(negedge clk) begin
    logic [DW-1:0] val;
    logic          ev;
    if (!rstn) begin
      for (int k = 0; k < NI; k++) begin
        exp_d[k] = '0;
        for (int s = 0; s < 4; s++) pend_v[k][s] = 1'b0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < NI; k++) begin
        if (re && !pwr[0]) begin
          val = (int'(ra) < dep(k)) ? m[k][ra] : '0;
          if (byp(k) == 1 && we && wa == ra && int'(wa) < dep(k))
            for (int l = 0; l < MW; l++)
              if (wmask[l]) val[l*LW +: LW] = di[l*LW +: LW];
          pend_v[k][(cyc + lat(k) - 1) % 4] = 1'b1;
          pend_d[k][(cyc + lat(k) - 1) % 4] = val;
        end
        if (we && !pwr[0] && int'(wa) < dep(k))
          for (int l = 0; l < MW; l++)
            if (wmask[l]) m[k][wa][l*LW +: LW] = di[l*LW +: LW];
      end
    end
    for (int k = 0; k < NI; k++) begin
      ev = rstn && pend_v[k][cyc % 4];
      if (ev) begin
        exp_d[k] = pend_d[k][cyc % 4];
        pend_v[k][cyc % 4] = 1'b0;
      end
      report("model", k, dout_a[k], vld_a[k], exp_d[k], ev);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(logic w, int aw_i, logic [MW-1:0] msk, logic [DW-1:0] d, logic r, int ar_i);
    logic [31:0] a1, a2;
    a1 = aw_i;
    a2 = ar_i;
    we = w; wa = a1[AW-1:0]; wmask = msk; di = d; re = r; ra = a2[AW-1:0];
    tick();
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] e, ones, a5, v9;
    logic [MW-1:0] full;
    ones = '1;
    full = '1;
    for (int i = 0; i < DW / 8; i++) a5[i*8 +: 8] = 8'hA5;

    repeat (3) tick();
    for (int k = 0; k < NI; k++) report("reset", k, dout_a[k], vld_a[k], '0, 1'b0);
    rstn = 1'b1;

    for (int a = 0; a < 64; a++) drive(1'b1, a, full, rnd(), 1'b0, 0);

    drive(1'b1, 5, full, a5, 1'b0, 0);
    drive(1'b0, 0, '0, '0, 1'b1, 5);
    report("rd5", 0, dout_a[0], vld_a[0], a5, 1'b1);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5, full, '0, 1'b0, 0);
      report("hold5", 0, dout_a[0], vld_a[0], a5, 1'b0);
    end

    drive(1'b1, 3, full, '0, 1'b0, 0);
    drive(1'b1, 3, 17'h00001, ones, 1'b0, 0);
    drive(1'b0, 0, '0, '0, 1'b1, 3);
    e = '0; e[63:0] = '1;
    report("mask3", 0, dout_a[0], vld_a[0], e, 1'b1);

    drive(1'b1, 7, full, '0, 1'b0, 0);
    drive(1'b1, 7, 17'h10000, ones, 1'b1, 7);
    e = '0; e[DW-1 -: 64] = '1;
    report("coll_byp", 0, dout_a[0], vld_a[0], e, 1'b1);
    report("coll_old", 1, dout_a[1], vld_a[1], '0, 1'b1);
    drive(1'b0, 0, '0, '0, 1'b1, 7);
    report("coll_after", 1, dout_a[1], vld_a[1], e, 1'b1);

    for (int i = 0; i < 4; i++) drive(1'b1, i, full, DW'(i), 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, '0, '0, 1'b1, i);
      if (i >= 1) report("oreg_b2b", 2, dout_a[2], vld_a[2], DW'(i - 1), 1'b1);
    end
    drive(1'b0, 0, '0, '0, 1'b0, 0);
    report("oreg_b2b", 2, dout_a[2], vld_a[2], DW'(3), 1'b1);
    drive(1'b0, 0, '0, '0, 1'b0, 0);
    report("oreg_end", 2, dout_a[2], vld_a[2], DW'(3), 1'b0);

    v9 = rnd(); v9[DW-1] = 1'b1;
    drive(1'b1, 9, full, v9, 1'b0, 0);
    drive(1'b0, 0, '0, '0, 1'b1, 9);
    pwr = 32'h1;
    drive(1'b1, 9, full, DW'(1), 1'b1, 9);
    report("pd_novld", 0, dout_a[0], vld_a[0], v9, 1'b0);
    pwr = 32'h0;
    drive(1'b0, 0, '0, '0, 1'b1, 9);
    report("pd_retain", 0, dout_a[0], vld_a[0], v9, 1'b1);

    drive(1'b1, 50, full, ones, 1'b0, 0);
    drive(1'b0, 0, '0, '0, 1'b1, 50);
    report("oob_in", 0, dout_a[0], vld_a[0], ones, 1'b1);
    drive(1'b0, 0, '0, '0, 1'b0, 0);
    report("oob_out", 3, dout_a[3], vld_a[3], '0, 1'b1);

    we = 1'b0; re = 1'b1; ra = 6'd1;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    re = 1'b0;
    #1;
    report("rst_mid", 2, dout_a[2], vld_a[2], '0, 1'b0);
    report("rst_mid", 0, dout_a[0], vld_a[0], '0, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
    report("rst_novld", 2, dout_a[2], vld_a[2], '0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      pwr = {$urandom_range(0, 1) == 1 ? 31'h0 : 31'($urandom), $urandom_range(0, 7) == 0};
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 63), MW'($urandom), rnd(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 63));
    end
    pwr = '0;
    drive(1'b0, 0, '0, '0, 1'b0, 0);
    drive(1'b0, 0, '0, '0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_ram_rws_param.md
Name: nv_ram_rws_param

Overview:
- Parametrised two-port RAM model for the FPGA RAM library: one synchronous write port and one synchronous read port.
- Successor to the fixed-geometry 64-entry read/write-split RAMs; depth and width are generalised.
- Adds per-lane write mask, selectable read-during-write bypass, optional output pipeline stage, read-data valid, held read data and power-down gating.
- Used by datapath buffers (CDMA/CACC style) that need masked partial writes and a known read latency.

Parameters:
- DEPTH, 64, number of entries
- AW, 6, address width; DEPTH <= 2**AW
- DW, 1088, data width
- MW, 17, write-mask lanes; DW % MW == 0; each lane is DW/MW bits
- BYPASS, 1, 1 = collision read returns new data; 0 = returns old data
- OUT_REG, 0, 0 = read latency 1; 1 = read latency 2

Ports:
- clk  input  1  clock; all state changes on posedge
- rstn  input  1  asynchronous active-low reset
- ra  input  AW  read address
- re  input  1  read enable
- dout  output  DW  read data, held between reads
- dout_vld  output  1  one-cycle pulse when dout carries new read data
- wa  input  AW  write address
- we  input  1  write enable
- wmask  input  MW  lane write enables; bit i covers di[(i+1)*DW/MW-1 : i*DW/MW]
- di  input  DW  write data
- pwrbus_ram_pd  input  32  power control; bit 0 = 1 puts the array in power-down

Behaviour:
- Reset (rstn low, asynchronous):
  - dout = 0, dout_vld = 0, stage-2 data and valid registers = 0.
  - Array contents are not reset; their values are undefined.
  - Deassertion is synchronous to clk, and the first access takes effect at the first posedge after release.
  - Reset during a pending read drops that read: no dout_vld for it.
- Power-down gating: pd = pwrbus_ram_pd[0]. A write is effective when we & !pd; a read is effective when re & !pd.
- Write: on an effective write at posedge, M[wa] lane i <= di lane i for each i with wmask[i] = 1. Other lanes are unchanged. If wmask = 0, nothing is written.
- Out-of-range address (>= DEPTH): writes are ignored, reads return 0, and dout_vld still pulses.
- Read stage 1: on an effective read at posedge T, rd_q <= M[ra] and v1 <= 1; otherwise rd_q holds and v1 <= 0.
- Collision (effective read and effective write, ra == wa, same edge):
  - BYPASS = 1: rd_q gets di on masked lanes and old contents on unmasked lanes.
  - BYPASS = 0: rd_q gets the old contents.
  - Either way, the array is updated.
- OUT_REG = 0: dout = rd_q, dout_vld = v1. Latency is 1; data is visible after edge T.
- OUT_REG = 1: stage 2 registers dout <= rd_q when v1 = 1, and dout_vld <= v1. Latency is 2.
- Hold: dout never changes except on a valid read. A later write to the same address does not alter dout.
- Throughput: one read and one write per cycle, back-to-back, no bubbles.
- pd asserted:
  - New reads produce no dout_vld, and dout holds.
  - With OUT_REG = 1, a read already in stage 1 still completes.
  - Array contents are retained in the model.
- X handling: any X on re or we when out of reset is flagged by a simulation-only assertion. Behaviour under X is undefined.

Test Plan:
- Reset, defaults: rstn low, then high; write M[5] = all 0xA5 bytes with wmask all-ones; read ra = 5 at cycle 10 -> dout = 0xA5.. and dout_vld = 1 at cycle 11 only; dout holds through cycle 20.
- Masked write: M[3] = 0 fully; then write di = all-ones with wmask = 17'h00001; read 3 -> dout[63:0] = all-ones, dout[1087:64] = 0.
- Collision, BYPASS = 1: M[7] = 0; same edge we = re = 1, wa = ra = 7, di = all-ones, wmask = 17'h10000 -> dout[1087:1024] = all-ones, rest 0. With BYPASS = 0 -> dout = 0, and a following read of 7 returns the masked value.
- OUT_REG = 1: back-to-back reads of addresses 0..3 on consecutive cycles, after writing M[i] = i -> dout = 0, 1, 2, 3 on cycles +2..+5, dout_vld high for 4 consecutive cycles.
- Power-down: pd = 1, we = 1 to addr 9 with di = 0x1, and re = 1 -> no dout_vld, M[9] unchanged (a read after pd = 0 returns the prior value), dout holds.
- Reset mid-read, OUT_REG = 1: re at T, rstn low between T and T+1 -> dout = 0, dout_vld = 0, no valid pulse after release.
